// File: rtl/sr_pkg.sv
// Shared types for the shift-register chain reader (and later the driver).
package sr_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StSettle,
        StShift
    } sr_state_t;

    localparam int unsigned SyncDepth = 2;

endpackage

// File: rtl/sr_reader_if.sv
// Host-side bus of sr_reader: frame request plus the captured word and its strobes.
interface sr_reader_if #(
    parameter int unsigned w_data = 16
) ();

    logic              start;
    logic [w_data-1:0] data;
    logic              valid;
    logic              busy;

    modport master (
        output start,
        input  data,
        input  valid,
        input  busy
    );

    modport slave (
        input  start,
        output data,
        output valid,
        output busy
    );

endinterface

// File: rtl/sync_2ff.sv
// Single-bit flop-chain synchronizer for the asynchronous serial input.
module sync_2ff
    import sr_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SyncDepth-1:0] sync_q;
    logic [SyncDepth-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SyncDepth-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SyncDepth-1];

endmodule

// File: rtl/sr_reader.sv
// Reads a 74HC165-style chain: load strobe, then w_data shift clocks, MSB first,
// presenting the word with a one-cycle valid strobe.
module sr_reader
    import sr_pkg::*;
#(
    parameter int unsigned w_data  = 16,
    parameter int unsigned clk_div = 4
) (
    input  logic         clk,
    input  logic         rst,
    sr_reader_if.slave   bus,
    output logic         sr_pl_n,
    output logic         sr_clk,
    input  logic         sr_q
);

    localparam int unsigned PhaseW = $clog2(clk_div);
    localparam int unsigned BitW   = $clog2(w_data);
    localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(clk_div - 1);
    localparam logic [BitW-1:0]   BitLast   = BitW'(w_data - 1);

    sr_state_t         state_q, state_d;
    logic [PhaseW-1:0] phase_q, phase_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic [w_data-1:0] shreg_q, shreg_d;
    logic [w_data-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              pl_n_q, pl_n_d;
    logic              sr_clk_q, sr_clk_d;
    logic              busy_q, busy_d;
    logic              q_s;
    logic              phase_end;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sr_q),
        .q   (q_s)
    );

    assign phase_end = (phase_q == PhaseLast);

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        pl_n_d   = pl_n_q;
        sr_clk_d = sr_clk_q;

        unique case (state_q)
            StIdle: begin
                pl_n_d   = 1'b1;
                sr_clk_d = 1'b0;
                if (bus.start) begin
                    state_d = StLoad;
                    pl_n_d  = 1'b0;
                    phase_d = '0;
                end
            end
            StLoad: begin
                if (phase_end) begin
                    state_d = StSettle;
                    pl_n_d  = 1'b1;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            StSettle: begin
                if (phase_end) begin
                    state_d = StShift;
                    phase_d = '0;
                    bit_d   = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            StShift: begin
                if (!phase_end) begin
                    phase_d = phase_q + 1'b1;
                end else begin
                    phase_d = '0;
                    if (!sr_clk_q) begin
                        // Sample at the end of the low phase, just before the chain shifts.
                        shreg_d  = {shreg_q[w_data-2:0], q_s};
                        sr_clk_d = 1'b1;
                    end else begin
                        sr_clk_d = 1'b0;
                        if (bit_q == BitLast) begin
                            state_d = StIdle;
                            data_d  = shreg_q;
                            valid_d = 1'b1;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            phase_q  <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            pl_n_q   <= 1'b1;
            sr_clk_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            pl_n_q   <= pl_n_d;
            sr_clk_q <= sr_clk_d;
            busy_q   <= busy_d;
        end
    end

    assign sr_pl_n   = pl_n_q;
    assign sr_clk    = sr_clk_q;
    assign bus.data  = data_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;

endmodule
